// File: rtl/pc_redirect_pkg.sv
// Shared types for the PC redirect unit: branch modes, FSM states, default alignment.
package pc_redirect_pkg;

    typedef enum logic [1:0] {
        BR_BEQ  = 2'b00,
        BR_BNE  = 2'b01,
        BR_JUMP = 2'b10,
        BR_RSVD = 2'b11
    } br_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    localparam int unsigned DEF_INSTR_BYTES = 4;
    localparam int unsigned ALIGN_LSB       = $clog2(DEF_INSTR_BYTES);

endpackage

// File: rtl/pc_redirect_unit_target_sel.sv
// Combinational decode of branch-taken and the aligned redirect target.
module pc_target_sel
    import pc_redirect_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ALIGN_W = ALIGN_LSB
) (
    input  logic              br_valid_i,
    input  br_mode_t          br_mode_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    output logic              taken_o,
    output logic [ADDR_W-1:0] target_o
);

    // Clears the sub-instruction offset bits so a redirect always lands on an instruction boundary.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_W) - ADDR_W'(1));

    logic [ADDR_W-1:0] raw_target;

    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves a latch.
        taken_o    = 1'b0;
        raw_target = br_target_i;
        unique case (br_mode_i)
            BR_BEQ:  taken_o = br_valid_i & zero_i;
            BR_BNE:  taken_o = br_valid_i & ~zero_i;
            BR_JUMP: begin
                taken_o    = br_valid_i;
                raw_target = jmp_target_i;
            end
            default: taken_o = 1'b0;
        endcase
        target_o = raw_target & ALIGN_MASK;
    end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner: sequential fetch, branch/jump redirect, stall hold with deferred redirect.
module pc_redirect_unit
    import pc_redirect_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int unsigned       INSTR_BYTES = DEF_INSTR_BYTES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              br_valid_i,
    input  logic [1:0]        br_mode_i,
    input  logic              zero_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic [ADDR_W-1:0] jmp_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus_o,
    output logic              flush_o,
    output logic              pend_o
);

    localparam int unsigned       ALIGN_W = $clog2(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pend_q;
    logic              flush_q;
    logic              pend_flag_q;
    logic              taken;
    logic [ADDR_W-1:0] target;

    pc_target_sel #(
        .ADDR_W  (ADDR_W),
        .ALIGN_W (ALIGN_W)
    ) u_target_sel (
        .br_valid_i   (br_valid_i),
        .br_mode_i    (br_mode_t'(br_mode_i)),
        .zero_i       (zero_i),
        .br_target_i  (br_target_i),
        .jmp_target_i (jmp_target_i),
        .taken_o      (taken),
        .target_o     (target)
    );

    assign pc_plus_o = pc_q + STEP;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            // NOTE: the pending target is reset too, so a redirect held at reset can never replay.
            pend_q      <= '0;
            flush_q     <= 1'b0;
            pend_flag_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    flush_q <= 1'b0;
                    if (start_i) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        pc_q    <= taken ? target : pc_plus_o;
                        flush_q <= taken;
                    end else begin
                        flush_q <= 1'b0;
                        if (taken) begin
                            pend_q      <= target;
                            pend_flag_q <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    // The held redirect wins over any branch presented while waiting.
                    if (!stall_i) begin
                        pc_q        <= pend_q;
                        flush_q     <= 1'b1;
                        pend_flag_q <= 1'b0;
                        state_q     <= ST_RUN;
                    end else begin
                        flush_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    flush_q     <= 1'b0;
                    pend_flag_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o   = pc_q;
    assign flush_o = flush_q;
    assign pend_o  = pend_flag_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: 32-bit instance for main behaviour, 8-bit instance for wrap.
module tb_pc_redirect_unit;
    import pc_redirect_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance, RESET_PC = 0
    logic        rst, start, stall, valid, zero;
    logic [1:0]  mode;
    logic [31:0] br_tgt, jmp_tgt, pc, pc_plus;
    logic        flush, pend;

    // 8-bit instance, RESET_PC = 0x10
    logic        rst8, start8, stall8, valid8, zero8;
    logic [1:0]  mode8;
    logic [7:0]  br_tgt8, jmp_tgt8, pc8, pc_plus8;
    logic        flush8, pend8;

    int n_cmp = 0;
    int n_err = 0;

    pc_redirect_unit #(.ADDR_W(32), .RESET_PC(32'h0), .INSTR_BYTES(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
        .br_valid_i(valid), .br_mode_i(mode), .zero_i(zero),
        .br_target_i(br_tgt), .jmp_target_i(jmp_tgt),
        .pc_o(pc), .pc_plus_o(pc_plus), .flush_o(flush), .pend_o(pend)
    );

    pc_redirect_unit #(.ADDR_W(8), .RESET_PC(8'h10), .INSTR_BYTES(4)) dut8 (
        .clk_i(clk), .rst_i(rst8), .start_i(start8), .stall_i(stall8),
        .br_valid_i(valid8), .br_mode_i(mode8), .zero_i(zero8),
        .br_target_i(br_tgt8), .jmp_target_i(jmp_tgt8),
        .pc_o(pc8), .pc_plus_o(pc_plus8), .flush_o(flush8), .pend_o(pend8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] e_pc, input logic e_fl, input logic e_pd);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
        check({tag, ".pend"}, {31'd0, pend}, {31'd0, e_pd});
    endtask

    task automatic check_pc8(input string tag, input logic [7:0] e_pc, input logic e_fl, input logic e_pd);
        check({tag, ".pc"}, {24'd0, pc8}, {24'd0, e_pc});
        check({tag, ".flush"}, {31'd0, flush8}, {31'd0, e_fl});
        check({tag, ".pend"}, {31'd0, pend8}, {31'd0, e_pd});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; valid = 1'b0; zero = 1'b0;
        mode = BR_BEQ; br_tgt = '0; jmp_tgt = '0;
        rst8 = 1'b1; start8 = 1'b0; stall8 = 1'b0; valid8 = 1'b0; zero8 = 1'b0;
        mode8 = BR_BEQ; br_tgt8 = '0; jmp_tgt8 = '0;

        // 1: reset, idle hold, sequential run
        step(); step();
        rst = 1'b0;
        step();
        check_pc("idle", 32'h0, 1'b0, 1'b0);
        step();
        check_pc("idle_no_start", 32'h0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        check_pc("start_edge", 32'h0, 1'b0, 1'b0);
        step(); check("seq1", pc, 32'h4);
        step(); check("seq2", pc, 32'h8);
        step(); check("seq3", pc, 32'hC);
        check("pc_plus", pc_plus, 32'h10);
        rst = 1'b1;
        #1;
        check_pc("async_rst", 32'h0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step(); check("rerun_edge", pc, 32'h0);
        step(); step(); step(); step();
        check("at_0x10", pc, 32'h10);

        // 2: BEQ taken / not taken
        valid = 1'b1; mode = BR_BEQ; zero = 1'b1; br_tgt = 32'h40;
        step(); check_pc("beq_taken", 32'h40, 1'b1, 1'b0);
        valid = 1'b0;
        step(); check_pc("after_beq", 32'h44, 1'b0, 1'b0);
        valid = 1'b1; zero = 1'b0;
        step(); check_pc("beq_not", 32'h48, 1'b0, 1'b0);

        // 3: BNE, JUMP with alignment, reserved, consecutive redirects
        mode = BR_BNE; zero = 1'b0; br_tgt = 32'h80;
        step(); check_pc("bne_taken", 32'h80, 1'b1, 1'b0);
        zero = 1'b1; br_tgt = 32'h300;
        step(); check_pc("bne_not", 32'h84, 1'b0, 1'b0);
        mode = BR_JUMP; jmp_tgt = 32'h103; br_tgt = 32'h600;
        step(); check_pc("jump_align", 32'h100, 1'b1, 1'b0);
        mode = BR_BEQ; zero = 1'b1; br_tgt = 32'h20;
        step(); check_pc("back2back", 32'h20, 1'b1, 1'b0);
        mode = BR_RSVD; jmp_tgt = 32'h700; br_tgt = 32'h800;
        step(); check_pc("rsvd", 32'h24, 1'b0, 1'b0);
        valid = 1'b0; mode = BR_JUMP;
        step(); check_pc("jump_invalid", 32'h28, 1'b0, 1'b0);

        // 4: stall with taken branch -> HOLD, newer branch ignored, release
        stall = 1'b1; valid = 1'b1; mode = BR_BEQ; zero = 1'b1; br_tgt = 32'h200;
        step(); check_pc("hold1", 32'h28, 1'b0, 1'b1);
        mode = BR_BNE; zero = 1'b0; br_tgt = 32'h500;
        step(); check_pc("hold2", 32'h28, 1'b0, 1'b1);
        step(); check_pc("hold3", 32'h28, 1'b0, 1'b1);
        stall = 1'b0;
        step(); check_pc("release", 32'h200, 1'b1, 1'b0);
        valid = 1'b0;
        step(); check_pc("post_rel", 32'h204, 1'b0, 1'b0);
        stall = 1'b1;
        step(); check_pc("stall_plain", 32'h204, 1'b0, 1'b0);
        stall = 1'b0; start = 1'b0;
        step(); check_pc("start_sticky", 32'h208, 1'b0, 1'b0);

        // Reset while holding a redirect on the 32-bit instance
        start = 1'b1; stall = 1'b1; valid = 1'b1; mode = BR_JUMP; jmp_tgt = 32'h900;
        step(); check_pc("hold_pre_rst", 32'h208, 1'b0, 1'b1);
        rst = 1'b1;
        #1; check_pc("rst_in_hold", 32'h0, 1'b0, 1'b0);
        step();
        rst = 1'b0; stall = 1'b0; valid = 1'b0;
        step(); check_pc("no_replay0", 32'h0, 1'b0, 1'b0);
        step(); check_pc("no_replay1", 32'h4, 1'b0, 1'b0);

        // 5: 8-bit instance: wrap and reset in HOLD
        rst8 = 1'b0;
        step(); check_pc8("w_idle", 8'h10, 1'b0, 1'b0);
        start8 = 1'b1;
        step(); check_pc8("w_start", 8'h10, 1'b0, 1'b0);
        valid8 = 1'b1; mode8 = BR_JUMP; jmp_tgt8 = 8'hFE;
        step(); check_pc8("w_jump", 8'hFC, 1'b1, 1'b0);
        check("w_plus_wrap", {24'd0, pc_plus8}, 32'h0);
        valid8 = 1'b0;
        step(); check_pc8("w_wrap", 8'h00, 1'b0, 1'b0);
        check("w_plus", {24'd0, pc_plus8}, 32'h4);
        stall8 = 1'b1; valid8 = 1'b1; mode8 = BR_BEQ; zero8 = 1'b1; br_tgt8 = 8'h80;
        step(); check_pc8("w_hold", 8'h00, 1'b0, 1'b1);
        rst8 = 1'b1;
        #1; check_pc8("w_rst_hold", 8'h10, 1'b0, 1'b0);
        step();
        rst8 = 1'b0; stall8 = 1'b0; valid8 = 1'b0;
        step(); check_pc8("w_rerun", 8'h10, 1'b0, 1'b0);
        step(); check_pc8("w_seq", 8'h14, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
